// File: rtl/lsu_load_align_queue.sv
// lsu_load_align_queue
//   Tracks outstanding loads between issue and writeback. Each issued load
//   pushes its {id, fn3, byte offset} into an attribute FIFO. In-order memory
//   responses fill a data FIFO. The two FIFO heads pair up to produce an
//   aligned, sign/zero-extended writeback result.
//
// Ports
//   clk, rst_n            clock; synchronous active-low reset
//   issue_valid/ready     load issue handshake (ready = room for another load)
//   issue_id/fn3/byte     attributes of the issued load
//   rsp_valid/rsp_data    in-order raw read words, no backpressure
//   wb_valid/ready        writeback handshake
//   wb_id/wb_data         ID and aligned result of the head load
//   outstanding           loads issued but not yet written back
//   rsp_err               sticky flag: a response arrived with no pending load
//
// Configuration
//   LSU_LOAD_ALIGN_OUT_REG_EN  when defined, results pass through a 2-entry
//                              output skid register (latency 2, full rate).

module lsu_load_align_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  output logic                       issue_ready,
  input  logic [ID_W-1:0]            issue_id,
  input  logic [2:0]                 issue_fn3,
  input  logic [1:0]                 issue_byte,
  input  logic                       rsp_valid,
  input  logic [31:0]                rsp_data,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic [ID_W-1:0]            wb_id,
  output logic [31:0]                wb_data,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       rsp_err
);

  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int ATTR_W = ID_W + 5;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                               input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec)      r = c + CNT_W'(1);
    else if (dec && !inc) r = c - CNT_W'(1);
    return r;
  endfunction

  function automatic logic [31:0] align_load(input logic [2:0] fn3,
                                             input logic [1:0] bsel,
                                             input logic [31:0] raw);
    logic [31:0] sh;
    sh = raw >> {bsel, 3'b000};
    case (fn3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return raw;
    endcase
  endfunction

  // Storage
  logic [ATTR_W-1:0] attr_mem [DEPTH];
  logic [31:0]       data_mem [DEPTH];

  // State
  logic [PTR_W-1:0] attr_wr_q, attr_wr_d, attr_rd_q, attr_rd_d;
  logic [PTR_W-1:0] data_wr_q, data_wr_d, data_rd_q, data_rd_d;
  logic [CNT_W-1:0] attr_cnt_q, attr_cnt_d, data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0] pend_q, pend_d, out_q, out_d;
  logic             err_q, err_d;

  logic             issue_fire, rsp_fire, head_valid, head_pop, wb_pop;
  logic [ID_W-1:0]  head_id;
  logic [2:0]       head_fn3;
  logic [1:0]       head_byte;
  logic [31:0]      aligned;

  // A new issue is only admitted against the registered count, so a
  // same-cycle writeback pop never frees a slot early.
  assign issue_ready = (out_q < DEPTH_C);
  assign issue_fire  = issue_valid & issue_ready;
  // Only loads issued in earlier cycles can absorb a response.
  assign rsp_fire    = rsp_valid & (pend_q != '0);
  assign head_valid  = (attr_cnt_q != '0) & (data_cnt_q != '0);

  assign {head_id, head_fn3, head_byte} = attr_mem[attr_rd_q];
  assign aligned = align_load(head_fn3, head_byte, data_mem[data_rd_q]);

  assign outstanding = out_q;
  assign rsp_err     = err_q;

`ifdef LSU_LOAD_ALIGN_OUT_REG_EN
  logic [ID_W+31:0] skid_mem [2];
  logic             skid_wr_q, skid_rd_q;
  logic [1:0]       skid_cnt_q;

  assign wb_valid          = (skid_cnt_q != 2'd0);
  assign {wb_id, wb_data}  = skid_mem[skid_rd_q];
  assign wb_pop            = wb_valid & wb_ready;
  // Refill the skid when it has room or is draining this cycle.
  assign head_pop          = head_valid & ((skid_cnt_q != 2'd2) | wb_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_wr_q  <= 1'b0;
      skid_rd_q  <= 1'b0;
      skid_cnt_q <= 2'd0;
    end else begin
      if (head_pop) begin
        skid_mem[skid_wr_q] <= {head_id, aligned};
        skid_wr_q           <= ~skid_wr_q;
      end
      if (wb_pop) skid_rd_q <= ~skid_rd_q;
      if (head_pop && !wb_pop)      skid_cnt_q <= skid_cnt_q + 2'd1;
      else if (wb_pop && !head_pop) skid_cnt_q <= skid_cnt_q - 2'd1;
    end
  end
`else
  assign wb_valid = head_valid;
  assign wb_id    = head_id;
  assign wb_data  = aligned;
  assign head_pop = head_valid & wb_ready;
  assign wb_pop   = head_pop;
`endif

  always_comb begin
    attr_wr_d  = attr_wr_q + PTR_W'(issue_fire);
    attr_rd_d  = attr_rd_q + PTR_W'(head_pop);
    data_wr_d  = data_wr_q + PTR_W'(rsp_fire);
    data_rd_d  = data_rd_q + PTR_W'(head_pop);
    attr_cnt_d = cnt_upd(attr_cnt_q, issue_fire, head_pop);
    data_cnt_d = cnt_upd(data_cnt_q, rsp_fire, head_pop);
    pend_d     = cnt_upd(pend_q, issue_fire, rsp_fire);
    out_d      = cnt_upd(out_q, issue_fire, wb_pop);
    err_d      = err_q | (rsp_valid & (pend_q == '0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      attr_wr_q  <= '0;
      attr_rd_q  <= '0;
      data_wr_q  <= '0;
      data_rd_q  <= '0;
      attr_cnt_q <= '0;
      data_cnt_q <= '0;
      pend_q     <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      attr_wr_q  <= attr_wr_d;
      attr_rd_q  <= attr_rd_d;
      data_wr_q  <= data_wr_d;
      data_rd_q  <= data_rd_d;
      attr_cnt_q <= attr_cnt_d;
      data_cnt_q <= data_cnt_d;
      pend_q     <= pend_d;
      out_q      <= out_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage carries no reset; the counters qualify its contents.
  always_ff @(posedge clk) begin
    if (issue_fire) attr_mem[attr_wr_q] <= {issue_id, issue_fn3, issue_byte};
    if (rsp_fire)   data_mem[data_wr_q] <= rsp_data;
  end

endmodule

// File: tb/tb_lsu_load_align_queue.sv
`timescale 1ns/1ps
module tb_lsu_load_align_queue;
  localparam int DEPTH = 4;
  localparam int ID_W  = 3;
  localparam int CW    = $clog2(DEPTH+1);
`ifdef LSU_LOAD_ALIGN_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int MS = 4096;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic            issue_ready;
  logic [ID_W-1:0] issue_id;
  logic [2:0]      issue_fn3;
  logic [1:0]      issue_byte;
  logic            rsp_valid;
  logic [31:0]     rsp_data;
  logic            wb_valid;
  logic            wb_ready;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_data;
  logic [CW-1:0]   outstanding;
  logic            rsp_err;

  lsu_load_align_queue #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_id(issue_id), .issue_fn3(issue_fn3), .issue_byte(issue_byte),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_id(wb_id), .wb_data(wb_data),
    .outstanding(outstanding), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: loads are numbered in issue order. A response belongs
  // to the oldest load without one; results retire in that same order.
  logic [ID_W-1:0] m_id   [MS];
  logic [2:0]      m_fn3  [MS];
  logic [1:0]      m_byte [MS];
  logic [31:0]     m_res  [MS];
  int              m_rdy  [MS];
  int              n_iss = 0, n_rsp = 0, n_pop = 0;
  bit              m_err = 1'b0;

  function automatic logic [31:0] ref_align(input logic [2:0] fn3, input logic [1:0] b,
                                            input logic [31:0] raw);
    int unsigned sh, v;
    sh = raw / (32'd1 << (8 * int'(b)));
    case (fn3)
      3'd0: begin v = sh % 256;   if (v >= 128)   v = v + 32'hFFFF_FF00; end
      3'd4: v = sh % 256;
      3'd1: begin v = sh % 65536; if (v >= 32768) v = v + 32'hFFFF_0000; end
      3'd5: v = sh % 65536;
      default: v = raw;
    endcase
    return v;
  endfunction

  function automatic bit m_wb_valid();
    return (n_pop < n_rsp) && (m_rdy[n_pop % MS] <= cyc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock, updating the model from the inputs of the cycle just
  // ended, then compare all DUT outputs against it.
  task automatic tick();
    bit v_now;
    int k;
    v_now = m_wb_valid();
    if (!rst_n) begin
      n_iss = 0; n_rsp = 0; n_pop = 0; m_err = 1'b0;
    end else begin
      if (rsp_valid) begin
        if (n_rsp < n_iss) begin
          k = n_rsp % MS;
          m_res[k] = ref_align(m_fn3[k], m_byte[k], rsp_data);
          m_rdy[k] = cyc + LAT;
          n_rsp++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (issue_valid && (n_iss - n_pop) < DEPTH) begin
        k = n_iss % MS;
        m_id[k] = issue_id; m_fn3[k] = issue_fn3; m_byte[k] = issue_byte;
        n_iss++;
      end
      if (v_now && wb_ready) n_pop++;
    end
    @(posedge clk); #1;
    cyc++;
    chk("m_issue_ready", 32'(issue_ready), 32'((n_iss - n_pop) < DEPTH));
    chk("m_outstanding", 32'(outstanding), 32'(n_iss - n_pop));
    chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
    chk("m_wb_valid", 32'(wb_valid), 32'(m_wb_valid()));
    if (m_wb_valid()) begin
      chk("m_wb_id", 32'(wb_id), 32'(m_id[n_pop % MS]));
      chk("m_wb_data", wb_data, m_res[n_pop % MS]);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; issue_valid = 1'b0; rsp_valid = 1'b0; wb_ready = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [ID_W-1:0] id;
    logic [2:0]      fn3;
    logic [1:0]      bsel;
    logic [31:0]     raw;
    logic [31:0]     exp;
  } vec_t;
  vec_t vecs [9];

  initial begin
    vecs[0] = '{3'd2, 3'b000, 2'd3, 32'h80FF_1234, 32'hFFFF_FF80};
    vecs[1] = '{3'd1, 3'b101, 2'd2, 32'h8001_0000, 32'h0000_8001};
    vecs[2] = '{3'd5, 3'b001, 2'd2, 32'h8001_0000, 32'hFFFF_8001};
    vecs[3] = '{3'd3, 3'b100, 2'd1, 32'h0000_AB00, 32'h0000_00AB};
    vecs[4] = '{3'd0, 3'b000, 2'd0, 32'h1234_567F, 32'h0000_007F};
    vecs[5] = '{3'd7, 3'b010, 2'd2, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[6] = '{3'd6, 3'b111, 2'd1, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[7] = '{3'd4, 3'b001, 2'd0, 32'h0001_7FFF, 32'h0000_7FFF};
    vecs[8] = '{3'd2, 3'b101, 2'd3, 32'hAB00_0000, 32'h0000_00AB};

    issue_id = '0; issue_fn3 = 3'b010; issue_byte = 2'd0; rsp_data = '0;
    do_reset();
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Single-load alignment vectors
    foreach (vecs[i]) begin
      issue_valid = 1'b1; issue_id = vecs[i].id; issue_fn3 = vecs[i].fn3; issue_byte = vecs[i].bsel;
      tick();
      issue_valid = 1'b0;
      chk("vec_no_early", 32'(wb_valid), 32'd0);
      rsp_valid = 1'b1; rsp_data = vecs[i].raw;
      tick();
      rsp_valid = 1'b0;
      for (int j = 1; j < LAT; j++) begin
        chk("vec_latency", 32'(wb_valid), 32'd0);
        tick();
      end
      chk("vec_wb_valid", 32'(wb_valid), 32'd1);
      chk("vec_wb_id", 32'(wb_id), 32'(vecs[i].id));
      chk("vec_wb_data", wb_data, vecs[i].exp);
      tick();
      chk("vec_hold_data", wb_data, vecs[i].exp);
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      chk("vec_drained", 32'(outstanding), 32'd0);
      $display("[TB] vec %0d fn3=%0d byte=%0d raw=0x%08h -> wb_data=0x%08h", i,
               vecs[i].fn3, vecs[i].bsel, vecs[i].raw, vecs[i].exp);
    end

    // Fill to DEPTH with writeback stalled, then drain in order
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_id = ID_W'(i + 4); issue_fn3 = 3'b010; issue_byte = 2'd0;
      tick();
    end
    chk("full_issue_ready", 32'(issue_ready), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd4);
    issue_id = 3'd7;
    for (int i = 0; i < 4; i++) begin
      rsp_valid = 1'b1; rsp_data = 32'h1000_0000 + 32'(i);
      tick();
    end
    rsp_valid = 1'b0; issue_valid = 1'b0;
    repeat (2) tick();
    chk("full_still_4", 32'(outstanding), 32'd4);
    wb_ready = 1'b1; issue_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(wb_valid), 32'd1);
      chk("drain_id", 32'(wb_id), 32'(i + 4));
      chk("drain_data", wb_data, 32'h1000_0000 + 32'(i));
      tick();
      if (i == 0) chk("no_same_cycle_credit", 32'(outstanding), 32'd3);
      issue_valid = 1'b0;
    end
    wb_ready = 1'b0;
    chk("drain_empty", 32'(wb_valid), 32'd0);
    chk("drain_ready", 32'(issue_ready), 32'd1);
    $display("[TB] full/drain sequence done");

    // Stray response with nothing pending
    do_reset();
    rsp_valid = 1'b1; rsp_data = 32'h5555_5555;
    tick();
    rsp_valid = 1'b0;
    repeat (3) tick();
    chk("stray_no_wb", 32'(wb_valid), 32'd0);
    chk("stray_err", 32'(rsp_err), 32'd1);
    // Same-cycle issue must not absorb a response with pending==0
    issue_valid = 1'b1; rsp_valid = 1'b1; issue_id = 3'd3; issue_fn3 = 3'b010;
    tick();
    issue_valid = 1'b0; rsp_valid = 1'b0;
    repeat (LAT + 1) tick();
    chk("same_cyc_no_wb", 32'(wb_valid), 32'd0);
    chk("same_cyc_out", 32'(outstanding), 32'd1);
    rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
    tick();
    rsp_valid = 1'b0;
    repeat (LAT - 1) tick();
    chk("same_cyc_late_wb", 32'(wb_valid), 32'd1);
    chk("same_cyc_data", wb_data, 32'h1234_5678);
    chk("err_sticky", 32'(rsp_err), 32'd1);
    wb_ready = 1'b1; tick(); wb_ready = 1'b0;
    do_reset();
    chk("err_cleared", 32'(rsp_err), 32'd0);
    $display("[TB] stray response sequence done");

    // Reset with loads in flight
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_id = ID_W'(i); tick();
    end
    issue_valid = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hAAAA_0001;
    tick();
    rsp_valid = 1'b0;
    chk("pre_rst_out", 32'(outstanding), 32'd3);
    do_reset();
    chk("mid_rst_out", 32'(outstanding), 32'd0);
    chk("mid_rst_wb", 32'(wb_valid), 32'd0);
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    chk("late_rsp_err", 32'(rsp_err), 32'd1);
    repeat (LAT + 1) tick();
    chk("late_rsp_no_wb", 32'(wb_valid), 32'd0);
    $display("[TB] mid-operation reset sequence done");

    // Back-to-back stream across pointer wrap
    do_reset();
    wb_ready = 1'b1;
    for (int k = 0; k <= 10 + LAT; k++) begin
      issue_valid = (k < 10); issue_id = ID_W'(k);
      issue_fn3 = 3'($urandom_range(0, 7)); issue_byte = 2'($urandom_range(0, 3));
      rsp_valid = (k >= 1 && k <= 10); rsp_data = $urandom;
      tick();
      chk("stream_valid", 32'(wb_valid), 32'((k + 1 >= 1 + LAT) && (k + 1 <= 10 + LAT)));
      chk("stream_out_bound", 32'(outstanding <= CW'(LAT + 1)), 32'd1);
    end
    issue_valid = 1'b0; rsp_valid = 1'b0; wb_ready = 1'b0;
    $display("[TB] streaming sequence done");

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst_n       = ($urandom_range(0, 399) != 0);
      issue_valid = ($urandom_range(0, 99) < 60);
      issue_id    = ID_W'($urandom);
      issue_fn3   = 3'($urandom);
      issue_byte  = 2'($urandom);
      rsp_valid   = (n_rsp < n_iss) ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 2);
      rsp_data    = $urandom;
      wb_ready    = ($urandom_range(0, 99) < 70);
      tick();
    end
    rst_n = 1'b1;
    $display("[TB] random phase done, %0d loads retired in final segment", n_pop);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule

// File: doc/lsu_load_align_queue.md
LSU_LOAD_ALIGN_QUEUE -- requirements
Module: lsu_load_align_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, max outstanding loads (power of 2, >=2).
REQ-002 SHALL have parameter ID_W, default 3, instruction-ID width.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port issue_valid  in  1  load issued to memory subunit this cycle.
REQ-006 SHALL have port issue_ready  out  1  room for another outstanding load.
REQ-007 SHALL have port issue_id  in  ID_W  ID of issued load.
REQ-008 SHALL have port issue_fn3  in  3  load width/sign code.
REQ-009 SHALL have port issue_byte  in  2  address bits [1:0].
REQ-010 SHALL have port rsp_valid  in  1  in-order memory read data, no backpressure.
REQ-011 SHALL have port rsp_data  in  32  raw 32-bit word.
REQ-012 SHALL have port wb_valid  out  1  aligned result available.
REQ-013 SHALL have port wb_ready  in  1  writeback accepts result.
REQ-014 SHALL have port wb_id  out  ID_W  ID of result.
REQ-015 SHALL have port wb_data  out  32  aligned, extended result.
REQ-016 SHALL have port outstanding  out  clog2(DEPTH+1)  loads issued, not yet written back.
REQ-017 SHALL have port rsp_err  out  1  sticky: response with no pending load.

Function
REQ-018 Issue accepted when issue_valid & issue_ready; SHALL push {id, fn3, byte} into attribute FIFO.
REQ-019 issue_ready SHALL equal (outstanding < DEPTH); same-cycle wb pop SHALL NOT credit issue_ready.
REQ-020 pending = issued minus responded; rsp_valid with pending==0 SHALL be dropped and set rsp_err; same-cycle issue SHALL NOT match that response.
REQ-021 Accepted response SHALL be written into a DEPTH-entry data FIFO; it never overflows by REQ-019.
REQ-022 wb_valid SHALL assert when attribute FIFO and data FIFO are both non-empty; head entries pair in order.
REQ-023 Result latency SHALL be exactly 1 cycle from rsp_valid to wb_valid when data FIFO was empty.
REQ-024 Pop of both FIFOs SHALL occur on wb_valid & wb_ready; one result per cycle maximum.
REQ-025 wb_id, wb_data SHALL hold stable while wb_valid & ~wb_ready.
REQ-026 Alignment: shifted = rsp_data >> (8*byte).
REQ-027 fn3 000 LB: sign-extend shifted[7:0]; 100 LBU: zero-extend shifted[7:0].
REQ-028 fn3 001 LH: sign-extend shifted[15:0]; 101 LHU: zero-extend shifted[15:0].
REQ-029 fn3 010 and all other codes: wb_data = rsp_data unshifted.
REQ-030 outstanding SHALL increment on accepted issue, decrement on wb pop, unchanged when both occur.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH with no bubble at wrap.

Reset
REQ-032 On rst_n low at clock edge: both FIFOs empty, outstanding=0, pending=0, rsp_err=0, wb_valid=0, issue_ready=1 from next cycle.
REQ-033 Reset mid-operation SHALL discard all pending loads and data; responses arriving after reset with pending==0 SHALL set rsp_err.
REQ-034 wb_id and wb_data values SHALL be don't-care while wb_valid=0.

Configuration
REQ-035 Macro LSU_LOAD_ALIGN_OUT_REG_EN defined: aligned result SHALL pass through a 2-entry output skid register; latency per REQ-023 becomes 2 cycles; full throughput at wb_ready=1; outstanding SHALL decrement only on output-register pop.
REQ-036 Macro undefined: wb outputs SHALL be combinational from FIFO heads, latency 1.

Verification
REQ-037 Issue id=2, fn3=000, byte=3; rsp 0x80FF_1234 -> next cycle wb_valid=1, wb_id=2, wb_data=0xFFFF_FF80.
REQ-038 Issue fn3=101, byte=2; rsp 0x8001_0000 -> wb_data=0x0000_8001; fn3=001 same rsp -> 0xFFFF_8001.
REQ-039 Issue 4 loads (DEPTH=4), wb_ready=0 -> issue_ready=0, outstanding=4; 4 rsps buffered; wb_ready=1 -> 4 results ids in issue order on consecutive cycles, then issue_ready=1.
REQ-040 rsp_valid with no prior issue -> no wb_valid, rsp_err=1 held until reset.
REQ-041 Continuous issue/rsp for 10 loads with wb_ready=1 -> one result per cycle across pointer wrap, outstanding never exceeds 2.
REQ-042 Reset with 3 outstanding -> outstanding=0, wb_valid=0 next cycle, late rsp sets rsp_err.
